// File: rtl/seg7_pkg.sv
// Shared types and glyph lookup for the multiplexed 7-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam int         DP_BIT  = 0;

  // Logical, active-high segment pattern ordered a..g for a hex nibble
  function automatic logic [6:0] seg_glyph(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b1111110;
      4'h1:    pattern = 7'b0110000;
      4'h2:    pattern = 7'b1101101;
      4'h3:    pattern = 7'b1111001;
      4'h4:    pattern = 7'b0110011;
      4'h5:    pattern = 7'b1011011;
      4'h6:    pattern = 7'b1011111;
      4'h7:    pattern = 7'b1110000;
      4'h8:    pattern = 7'b1111111;
      4'h9:    pattern = 7'b1111011;
      4'hA:    pattern = 7'b1110111;
      4'hB:    pattern = 7'b0011111;
      4'hC:    pattern = 7'b1001110;
      4'hD:    pattern = 7'b0111101;
      4'hE:    pattern = 7'b1001111;
      default: pattern = 7'b1000111;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot/digit counters and OFF/ACTIVE/GAP state machine for the scan driver.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 500,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_enable,
  output logic [IW-1:0] o_dig_idx,
  output logic          o_active,
  output logic          o_snapshot_strobe
);

  localparam int ACTIVE_LEN = SCAN_DIV - GAP_CYCLES;

  scan_state_t   r_state;
  scan_state_t   w_state_nxt;
  logic [CW-1:0] r_slot_cnt;
  logic [CW-1:0] w_slot_nxt;
  logic [IW-1:0] r_dig_idx;
  logic [IW-1:0] w_dig_nxt;
  logic          w_strobe;
  logic          w_slot_wrap;
  logic          w_last_digit;

  assign w_slot_wrap  = (r_slot_cnt == CW'(SCAN_DIV - 1));
  assign w_last_digit = (r_dig_idx == IW'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= OFF;
      r_slot_cnt <= '0;
      r_dig_idx  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_cnt <= w_slot_nxt;
      r_dig_idx  <= w_dig_nxt;
    end
  end

  // ACTIVE vs GAP is decided from the slot count the next cycle will hold
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot_cnt;
    w_dig_nxt   = r_dig_idx;
    w_strobe    = 1'b0;
    case (r_state)
      OFF: begin
        w_slot_nxt = '0;
        w_dig_nxt  = '0;
        if (i_enable) begin
          w_state_nxt = ACTIVE;
          w_strobe    = 1'b1;
        end
      end
      default: begin
        if (!i_enable) begin
          w_state_nxt = OFF;
          w_slot_nxt  = '0;
          w_dig_nxt   = '0;
        end else begin
          if (w_slot_wrap) begin
            w_slot_nxt = '0;
            w_dig_nxt  = w_last_digit ? '0 : r_dig_idx + IW'(1);
            w_strobe   = w_last_digit;
          end else begin
            w_slot_nxt = r_slot_cnt + CW'(1);
          end
          w_state_nxt = (int'(w_slot_nxt) < ACTIVE_LEN) ? ACTIVE : GAP;
        end
      end
    endcase
  end

  assign o_dig_idx         = r_dig_idx;
  assign o_active          = (r_state == ACTIVE);
  assign o_snapshot_strobe = w_strobe & rst_n;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: frame snapshot, leading-zero
// blanking and registered, polarity-configurable anode/segment outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lzb_en,
  output logic [N_DIGITS-1:0]   an_out,
  output logic [7:0]            seg_out,
  output logic                  frame_start
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [IW-1:0]         w_dig_idx;
  logic                  w_active;
  logic                  w_strobe;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS-1:0]   r_dp;
  logic [N_DIGITS-1:0]   r_blank;
  logic                  r_lzb;
  logic [N_DIGITS-1:0]   w_suppress;
  logic                  w_run;
  logic [4*N_DIGITS-1:0] w_shifted;
  logic [3:0]            w_cur_digit;
  logic [N_DIGITS-1:0]   w_an;
  logic [7:0]            w_seg;
  logic [N_DIGITS-1:0]   r_an;
  logic [7:0]            r_seg;

  seg7_slot_timer #(
    .N_DIGITS  (N_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_timer (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_enable         (enable),
    .o_dig_idx        (w_dig_idx),
    .o_active         (w_active),
    .o_snapshot_strobe(w_strobe)
  );

  // Inputs are only sampled at frame boundaries so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_dp     <= '0;
      r_blank  <= '0;
      r_lzb    <= 1'b0;
    end else if (w_strobe) begin
      r_digits <= digits;
      r_dp     <= dp_mask;
      r_blank  <= blank_mask;
      r_lzb    <= lzb_en;
    end
  end

  always_comb begin
    w_suppress = '0;
    w_run      = r_lzb;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_run         = w_run && (r_digits[4*k +: 4] == 4'd0) && !r_dp[k];
      w_suppress[k] = w_run;
    end
  end

  assign w_shifted   = r_digits >> {w_dig_idx, 2'b00};
  assign w_cur_digit = w_shifted[3:0];

  always_comb begin
    w_an  = '0;
    w_seg = {SEG_OFF, 1'b0};
    if (w_active) begin
      w_an = {{(N_DIGITS-1){1'b0}}, 1'b1} << w_dig_idx;
      if (!r_blank[w_dig_idx]) begin
        w_seg[7:1]    = w_suppress[w_dig_idx] ? SEG_OFF : seg_glyph(w_cur_digit);
        w_seg[DP_BIT] = r_dp[w_dig_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= {N_DIGITS{AN_ACTIVE_LOW}};
      r_seg <= {8{SEG_ACTIVE_LOW}};
    end else begin
      r_an  <= AN_ACTIVE_LOW  ? ~w_an  : w_an;
      r_seg <= SEG_ACTIVE_LOW ? ~w_seg : w_seg;
    end
  end

  assign an_out      = r_an;
  assign seg_out     = r_seg;
  assign frame_start = w_strobe;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: active-high and active-low instances
// driven in parallel and compared against a small reference model.
module tb_seg7_scan_driver;

  localparam int N    = 4;
  localparam int DIV  = 8;
  localparam int GAPC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        lzb_en;
  logic [3:0]  an_hi, an_lo;
  logic [7:0]  seg_hi, seg_lo;
  logic        fs_hi, fs_lo;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(DIV), .GAP_CYCLES(GAPC),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dutHi (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .lzb_en(lzb_en),
    .an_out(an_hi), .seg_out(seg_hi), .frame_start(fs_hi)
  );

  seg7_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(DIV), .GAP_CYCLES(GAPC),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dutLo (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .lzb_en(lzb_en),
    .an_out(an_lo), .seg_out(seg_lo), .frame_start(fs_lo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [6:0] refGlyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  // Expected active-high seg_out for digit d of a snapshot
  function automatic logic [7:0] expSeg(input logic [15:0] dg, input logic [3:0] dp,
                                        input logic [3:0] bl, input logic lz, input int d);
    logic       supp;
    logic [3:0] nib;
    supp = lz && (d > 0);
    for (int k = 3; k >= d; k--) begin
      nib = dg[4*k +: 4];
      if (nib != 4'h0 || dp[k]) supp = 1'b0;
    end
    if (bl[d]) return 8'h00;
    nib = dg[4*d +: 4];
    return {supp ? 7'b0 : refGlyph(nib), dp[d]};
  endfunction

  task automatic checkDark(input string tag);
    checkOutput({tag, " an_hi"}, {28'b0, an_hi}, 32'h0);
    checkOutput({tag, " seg_hi"}, {24'b0, seg_hi}, 32'h0);
    checkOutput({tag, " an_lo"}, {28'b0, an_lo}, 32'hF);
    checkOutput({tag, " seg_lo"}, {24'b0, seg_lo}, 32'hFF);
  endtask

  // Called at the negedge just before slot 0 is visible; the next frame's
  // inputs are applied mid-frame (k=10) and must not show until next frame
  task automatic applyStimulus(input string tag,
                               input logic [15:0] dg, input logic [3:0] dp,
                               input logic [3:0] bl, input logic lz,
                               input logic [15:0] nDg, input logic [3:0] nDp,
                               input logic [3:0] nBl, input logic nLz);
    int         d;
    int         s;
    logic [3:0] eAn;
    logic [7:0] eSeg;
    logic [3:0] eAnLo;
    logic [7:0] eSegLo;
    for (int k = 0; k < N * DIV; k++) begin
      @(negedge clk);
      d      = k / DIV;
      s      = k % DIV;
      eAn    = (s < DIV - GAPC) ? (4'b0001 << d) : 4'b0000;
      eSeg   = (s < DIV - GAPC) ? expSeg(dg, dp, bl, lz, d) : 8'h00;
      eAnLo  = ~eAn;
      eSegLo = ~eSeg;
      checkOutput($sformatf("%s an_hi k%0d", tag, k), {28'b0, an_hi}, {28'b0, eAn});
      checkOutput($sformatf("%s seg_hi k%0d", tag, k), {24'b0, seg_hi}, {24'b0, eSeg});
      checkOutput($sformatf("%s an_lo k%0d", tag, k), {28'b0, an_lo}, {28'b0, eAnLo});
      checkOutput($sformatf("%s seg_lo k%0d", tag, k), {24'b0, seg_lo}, {24'b0, eSegLo});
      checkOutput($sformatf("%s fs_hi k%0d", tag, k), {31'b0, fs_hi}, {31'b0, (k == N*DIV - 2)});
      checkOutput($sformatf("%s fs_lo k%0d", tag, k), {31'b0, fs_lo}, {31'b0, (k == N*DIV - 2)});
      if (k == 10) begin
        digits     = nDg;
        dp_mask    = nDp;
        blank_mask = nBl;
        lzb_en     = nLz;
      end
    end
  endtask

  // Enable (or reset release) has just caused OFF->ACTIVE in this cycle
  task automatic startScan(input string tag);
    #1;
    checkOutput({tag, " frame_start"}, {31'b0, fs_hi}, 32'h1);
    @(negedge clk);
    checkDark({tag, " lag"});
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    digits     = 16'h0;
    dp_mask    = 4'h0;
    blank_mask = 4'h0;
    lzb_en     = 1'b0;
    repeat (3) @(negedge clk);
    checkDark("reset");
    checkOutput("reset fs", {31'b0, fs_hi}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkDark("idle");
      checkOutput("idle fs", {31'b0, fs_hi}, 32'h0);
    end

    digits = 16'h1234;
    enable = 1'b1;
    startScan("enable");
    applyStimulus("scan", 16'h1234, 4'h0, 4'h0, 1'b0, 16'h0305, 4'h0, 4'h0, 1'b1);
    applyStimulus("lzb", 16'h0305, 4'h0, 4'h0, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
    applyStimulus("zero", 16'h0000, 4'h0, 4'h0, 1'b1, 16'h0005, 4'h4, 4'h0, 1'b1);
    applyStimulus("dp", 16'h0005, 4'h4, 4'h0, 1'b1, 16'h0005, 4'h4, 4'h1, 1'b1);
    applyStimulus("blank", 16'h0005, 4'h4, 4'h1, 1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("pre-reset an", {28'b0, an_hi}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkDark("midreset");
    checkOutput("midreset fs", {31'b0, fs_hi}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    startScan("rerun");
    applyStimulus("restart", 16'h1234, 4'h0, 4'h0, 1'b0, 16'h1234, 4'h0, 4'h0, 1'b0);

    for (int j = 0; j < N * DIV - 1; j++) @(negedge clk);
    checkOutput("snap cycle fs", {31'b0, fs_hi}, 32'h1);
    digits = 16'h0305;
    lzb_en = 1'b1;
    enable = 1'b0;
    #1;
    checkOutput("disable fs_hi", {31'b0, fs_hi}, 32'h0);
    checkOutput("disable fs_lo", {31'b0, fs_lo}, 32'h0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checkDark("off");
      checkOutput("off fs", {31'b0, fs_hi}, 32'h0);
    end
    enable = 1'b1;
    startScan("reenable");
    applyStimulus("after off", 16'h0305, 4'h0, 4'h0, 1'b1, 16'h0305, 4'h0, 4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
